// File: rtl/pipeline_exec_ctrl.sv
// rtl/pipeline_exec_ctrl.sv - run/step/halt sequencer driving MIPS pipeline and PC enables.
// Enables are decoded from registered state only, so commands take effect one cycle after sampling.
module pipeline_exec_ctrl #(
   parameter int CYCLE_BITS   = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_run,
   input  logic                  i_step,
   input  logic                  i_abort,
   input  logic                  i_clear,
   input  logic                  i_halt_fetched,
   output logic                  o_pipe_en,
   output logic                  o_pc_en,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_halted,
   output logic [CYCLE_BITS-1:0] o_cycle_cnt,
   output logic [2:0]            o_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   state_t                  state_q, state_d;
   logic                    halt_seen_q, halt_seen_d;
   logic [3:0]              drain_cnt_q, drain_cnt_d;
   logic [CYCLE_BITS-1:0]   cycle_cnt_q, cycle_cnt_d;
   logic                    done_q, done_d;
   logic                    pipe_en;

   assign pipe_en = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         halt_seen_q <= 1'b0;
         drain_cnt_q <= 4'd0;
         cycle_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         halt_seen_q <= halt_seen_d;
         drain_cnt_q <= drain_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      halt_seen_d = halt_seen_q;
      drain_cnt_d = drain_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      if (pipe_en && !(&cycle_cnt_q)) begin
         cycle_cnt_d = cycle_cnt_q + CYCLE_BITS'(1);
      end

      if (i_abort) begin
         // Abort keeps count and halt tracking so a later run finishes the drain.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_clear) begin
                  cycle_cnt_d = '0;
                  halt_seen_d = 1'b0;
                  drain_cnt_d = 4'd0;
               end else if (i_run) begin
                  if (halt_seen_q) begin
                     state_d     = ST_DRAIN;
                     drain_cnt_d = DRAIN_LOAD;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else if (i_step) begin
                  state_d = ST_STEP;
               end
            end
            ST_RUN: begin
               if (i_halt_fetched) begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
                  halt_seen_d = 1'b1;
               end
            end
            ST_STEP: begin
               state_d = ST_IDLE;
               if (!halt_seen_q && i_halt_fetched) begin
                  halt_seen_d = 1'b1;
                  drain_cnt_d = DRAIN_LOAD;
               end else if (halt_seen_q) begin
                  drain_cnt_d = (drain_cnt_q != 4'd0) ? drain_cnt_q - 4'd1 : 4'd0;
                  if (drain_cnt_q <= 4'd1) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DRAIN: begin
               drain_cnt_d = (drain_cnt_q != 4'd0) ? drain_cnt_q - 4'd1 : 4'd0;
               if (drain_cnt_q <= 4'd1) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_clear) begin
                  state_d     = ST_IDLE;
                  cycle_cnt_d = '0;
                  halt_seen_d = 1'b0;
                  drain_cnt_d = 4'd0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   assign o_pipe_en   = pipe_en;
   assign o_pc_en     = (state_q == ST_RUN) || ((state_q == ST_STEP) && !halt_seen_q);
   assign o_busy      = pipe_en;
   assign o_done      = done_q;
   assign o_halted    = (state_q == ST_DONE);
   assign o_cycle_cnt = cycle_cnt_q;
   assign o_state     = state_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// tb/tb_pipeline_exec_ctrl.sv - directed self-checking bench for pipeline_exec_ctrl.
module tb_pipeline_exec_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run, step, abort, clear, hf;
   logic        pipe_en, pc_en, busy, done, halted;
   logic [31:0] cnt;
   logic [2:0]  state;
   logic        pipe_en4, pc_en4, busy4, done4, halted4;
   logic [3:0]  cnt4;
   logic [2:0]  state4;
   int          passed;
   int          total;

   pipeline_exec_ctrl #(.CYCLE_BITS(32), .DRAIN_CYCLES(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step), .i_abort(abort),
      .i_clear(clear), .i_halt_fetched(hf), .o_pipe_en(pipe_en), .o_pc_en(pc_en),
      .o_busy(busy), .o_done(done), .o_halted(halted), .o_cycle_cnt(cnt), .o_state(state)
   );

   pipeline_exec_ctrl #(.CYCLE_BITS(4), .DRAIN_CYCLES(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step), .i_abort(abort),
      .i_clear(clear), .i_halt_fetched(hf), .o_pipe_en(pipe_en4), .o_pc_en(pc_en4),
      .o_busy(busy4), .o_done(done4), .o_halted(halted4), .o_cycle_cnt(cnt4), .o_state(state4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      rst_n = 1'b1;
      run = 1'b1; tick(); run = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      total++; if (cnt !== 32'd6 || state !== 3'd1) $display("FAIL pre_reset: cnt=%0d state=%0d required 6/1", cnt, state); else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if (state !== 3'd0 || state4 !== 3'd0) $display("FAIL reset_state: got %0d/%0d required 0", state, state4); else passed++;
      total++; if ({pipe_en, pc_en, busy, done, halted} !== 5'b0) $display("FAIL reset_flags: got %b required 00000", {pipe_en, pc_en, busy, done, halted}); else passed++;
      total++; if (cnt !== 32'd0 || cnt4 !== 4'd0) $display("FAIL reset_cnt: got %0d/%0d required 0", cnt, cnt4); else passed++;
      for (int i = 0; i < 3; i++) tick();
      total++; if (state !== 3'd0 || pipe_en !== 1'b0) $display("FAIL reset_hold: state=%0d pipe_en=%0d required 0/0", state, pipe_en); else passed++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_halt_run();
      int np, npc, nd, ndr;
      np = 0; npc = 0; nd = 0; ndr = 0;
      run = 1'b1; tick(); run = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         hf = (c >= 10);
         if (pipe_en) np++;
         if (pc_en) npc++;
         if (done) nd++;
         if (c >= 11 && c <= 14 && pipe_en && !pc_en) ndr++;
         tick();
      end
      hf = 1'b0;
      total++; if (np !== 14) $display("FAIL halt_pipe_cycles: got %0d required 14", np); else passed++;
      total++; if (npc !== 10) $display("FAIL halt_pc_cycles: got %0d required 10", npc); else passed++;
      total++; if (ndr !== 4) $display("FAIL halt_drain_cycles: got %0d required 4", ndr); else passed++;
      total++; if (nd !== 1) $display("FAIL halt_done_pulses: got %0d required 1", nd); else passed++;
      total++; if (cnt !== 32'd14) $display("FAIL halt_cycle_cnt: got %0d required 14", cnt); else passed++;
      total++; if (halted !== 1'b1 || state !== 3'd4 || done !== 1'b0) $display("FAIL halt_final: halted=%0d state=%0d done=%0d required 1/4/0", halted, state, done); else passed++;
      clear = 1'b1; tick(); clear = 1'b0;
      total++; if (state !== 3'd0 || cnt !== 32'd0 || halted !== 1'b0) $display("FAIL clear_in_done: state=%0d cnt=%0d halted=%0d required 0/0/0", state, cnt, halted); else passed++;
   endtask

   task automatic test_step();
      for (int k = 0; k < 3; k++) begin
         step = 1'b1; tick(); step = 1'b0;
         total++; if ({pipe_en, pc_en, state} !== {1'b1, 1'b1, 3'd2}) $display("FAIL step_pulse%0d: got %b%b/%0d required 11/2", k, pipe_en, pc_en, state); else passed++;
         tick();
         total++; if (state !== 3'd0 || pipe_en !== 1'b0) $display("FAIL step_idle%0d: state=%0d pipe_en=%0d required 0/0", k, state, pipe_en); else passed++;
         for (int i = 0; i < 3; i++) tick();
      end
      total++; if (cnt !== 32'd3) $display("FAIL step_cycle_cnt: got %0d required 3", cnt); else passed++;
   endtask

   task automatic test_step_halt();
      clear = 1'b1; tick(); clear = 1'b0;
      total++; if (cnt !== 32'd0) $display("FAIL clear_in_idle: got %0d required 0", cnt); else passed++;
      for (int s = 1; s <= 5; s++) begin
         step = 1'b1; tick(); step = 1'b0;
         hf = 1'b1;
         total++; if (pipe_en !== 1'b1 || pc_en !== (s == 1)) $display("FAIL step_halt_en%0d: pipe=%0d pc=%0d required 1/%0d", s, pipe_en, pc_en, (s == 1)); else passed++;
         tick();
         hf = 1'b0;
         total++; if (state !== ((s == 5) ? 3'd4 : 3'd0)) $display("FAIL step_halt_state%0d: got %0d required %0d", s, state, (s == 5) ? 4 : 0); else passed++;
      end
      total++; if (done !== 1'b1) $display("FAIL step_halt_done: got %0d required 1", done); else passed++;
      total++; if (cnt !== 32'd5) $display("FAIL step_halt_cnt: got %0d required 5", cnt); else passed++;
      step = 1'b1; tick(); step = 1'b0;
      total++; if (state !== 3'd4 || done !== 1'b0 || pipe_en !== 1'b0) $display("FAIL step_in_done: state=%0d done=%0d pipe=%0d required 4/0/0", state, done, pipe_en); else passed++;
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic test_run_step_abort();
      int ndr;
      ndr = 0;
      run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0;
      total++; if (state !== 3'd1) $display("FAIL run_step_prio: got %0d required 1", state); else passed++;
      hf = 1'b1; tick(); hf = 1'b0;
      total++; if (state !== 3'd3 || pc_en !== 1'b0 || pipe_en !== 1'b1) $display("FAIL drain_entry: state=%0d pc=%0d pipe=%0d required 3/0/1", state, pc_en, pipe_en); else passed++;
      tick(); tick();
      abort = 1'b1;
      total++; if (pipe_en !== 1'b1 || state !== 3'd3) $display("FAIL abort_cycle_enabled: pipe=%0d state=%0d required 1/3", pipe_en, state); else passed++;
      tick(); abort = 1'b0;
      total++; if (state !== 3'd0 || done !== 1'b0 || pipe_en !== 1'b0) $display("FAIL abort_idle: state=%0d done=%0d pipe=%0d required 0/0/0", state, done, pipe_en); else passed++;
      tick();
      total++; if (done !== 1'b0 || halted !== 1'b0) $display("FAIL abort_no_done: done=%0d halted=%0d required 0/0", done, halted); else passed++;
      run = 1'b1; tick(); run = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (state == 3'd3 && pipe_en && !pc_en) ndr++;
         tick();
      end
      total++; if (ndr !== 4) $display("FAIL redrain_cycles: got %0d required 4", ndr); else passed++;
      total++; if (state !== 3'd4 || done !== 1'b1) $display("FAIL redrain_done: state=%0d done=%0d required 4/1", state, done); else passed++;
      total++; if (cnt !== 32'd8) $display("FAIL abort_keeps_cnt: got %0d required 8", cnt); else passed++;
   endtask

   task automatic test_saturate();
      clear = 1'b1; tick(); clear = 1'b0;
      run = 1'b1; tick(); run = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 10) clear = 1'b1;
         tick();
         clear = 1'b0;
      end
      total++; if (state !== 3'd1) $display("FAIL clear_in_run_state: got %0d required 1", state); else passed++;
      total++; if (cnt !== 32'd20) $display("FAIL clear_in_run_cnt: got %0d required 20", cnt); else passed++;
      total++; if (cnt4 !== 4'd15) $display("FAIL saturate_cnt: got %0d required 15", cnt4); else passed++;
      abort = 1'b1; tick(); abort = 1'b0;
      total++; if (state !== 3'd0 || busy !== 1'b0 || cnt !== 32'd21 || cnt4 !== 4'd15) $display("FAIL abort_in_run: state=%0d busy=%0d cnt=%0d cnt4=%0d required 0/0/21/15", state, busy, cnt, cnt4); else passed++;
   endtask

   initial begin
      passed = 0; total = 0;
      rst_n = 1'b1;
      run = 1'b0; step = 1'b0; abort = 1'b0; clear = 1'b0; hf = 1'b0;
      #2 rst_n = 1'b0;
      test_reset();
      test_halt_run();
      test_step();
      test_step_halt();
      test_run_step_abort();
      test_saturate();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
